// File: rtl/exmem_memwb_fwd_unit_pkg.sv
// Shared encodings and pipeline-entry layout for the EX/MEM + MEM/WB forwarding slice.
package exmem_memwb_fwd_unit_pkg;

  localparam int PIPE_DATA_W = 32;
  localparam int PIPE_REG_AW = 5;

  localparam logic [1:0] FWD_SEL_RF    = 2'b00;
  localparam logic [1:0] FWD_SEL_EXMEM = 2'b01;
  localparam logic [1:0] FWD_SEL_MEMWB = 2'b10;

  localparam logic [PIPE_REG_AW-1:0] REG_ZERO = '0;

  // The data field holds the ALU result in EX/MEM and the write-back value in MEM/WB.
  typedef struct packed {
    logic                   valid;
    logic                   reg_write;
    logic                   mem_to_reg;
    logic [PIPE_REG_AW-1:0] rd;
    logic [PIPE_DATA_W-1:0] data;
  } pipe_entry_t;

endpackage

// File: rtl/exmem_memwb_fwd_unit_fwd_sel.sv
// Operand forwarding select: purely combinational, EX/MEM beats MEM/WB, never emits 2'b11.
module fwd_sel_logic
  import exmem_memwb_fwd_unit_pkg::*;
#(
  parameter int REG_AW = PIPE_REG_AW
) (
  input  logic              i_exmem_valid,
  input  logic              i_exmem_reg_write,
  input  logic              i_exmem_mem_to_reg,
  input  logic [REG_AW-1:0] i_exmem_rd,
  input  logic              i_memwb_valid,
  input  logic              i_memwb_reg_write,
  input  logic [REG_AW-1:0] i_memwb_rd,
  input  logic [REG_AW-1:0] i_src,
  output logic [1:0]        o_sel
);

  logic w_exmem_hit;
  logic w_memwb_hit;

  // A load in EX/MEM has no data yet; the stall logic guarantees it is picked up from MEM/WB.
  assign w_exmem_hit = i_exmem_valid & i_exmem_reg_write & ~i_exmem_mem_to_reg &
                       (i_exmem_rd != '0) & (i_exmem_rd == i_src);
  assign w_memwb_hit = i_memwb_valid & i_memwb_reg_write &
                       (i_memwb_rd != '0) & (i_memwb_rd == i_src);

  always_comb begin
    o_sel = FWD_SEL_RF;
    if (w_exmem_hit) begin
      o_sel = FWD_SEL_EXMEM;
    end else if (w_memwb_hit) begin
      o_sel = FWD_SEL_MEMWB;
    end
  end

endmodule

// File: rtl/exmem_memwb_fwd_unit.sv
// EX/MEM + MEM/WB registers, operand forwarding selects and load-use detect; 1/2-cycle result latency.
// hold freezes both stages (beats flush_exmem); FWD_PERF_CNT_EN adds forwarding/stall counters.
module exmem_memwb_fwd_unit
  import exmem_memwb_fwd_unit_pkg::*;
#(
  parameter int DATA_W = PIPE_DATA_W,
  parameter int REG_AW = PIPE_REG_AW
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              hold,
  input  logic              flush_exmem,
  input  logic              ex_valid,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_reg_write,
  input  logic              ex_mem_to_reg,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic [DATA_W-1:0] mem_read_data,
  input  logic [REG_AW-1:0] idex_rs,
  input  logic [REG_AW-1:0] idex_rt,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  output logic [1:0]        forwarding_sel_a,
  output logic [1:0]        forwarding_sel_b,
  output logic [DATA_W-1:0] ALU_Result_out,
  output logic [DATA_W-1:0] MemToReg_Res_out,
  output logic [REG_AW-1:0] wb_rd,
  output logic              wb_reg_write,
  output logic              load_use_hazard
`ifdef FWD_PERF_CNT_EN
  ,
  output logic [31:0]       fwd_cnt,
  output logic [31:0]       lu_stall_cnt
`endif
);

  pipe_entry_t r_exmem;
  pipe_entry_t r_memwb;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_exmem <= '0;
      r_memwb <= '0;
    end else if (!hold) begin
      r_exmem.valid      <= ex_valid & ~flush_exmem;
      r_exmem.reg_write  <= ex_reg_write;
      r_exmem.mem_to_reg <= ex_mem_to_reg;
      r_exmem.rd         <= ex_rd;
      r_exmem.data       <= ex_alu_result;

      r_memwb.valid      <= r_exmem.valid;
      r_memwb.reg_write  <= r_exmem.reg_write;
      r_memwb.mem_to_reg <= r_exmem.mem_to_reg;
      r_memwb.rd         <= r_exmem.rd;
      r_memwb.data       <= r_exmem.mem_to_reg ? mem_read_data : r_exmem.data;
    end
  end

  fwd_sel_logic #(.REG_AW(REG_AW)) u_fwd_sel_a (
    .i_exmem_valid      (r_exmem.valid),
    .i_exmem_reg_write  (r_exmem.reg_write),
    .i_exmem_mem_to_reg (r_exmem.mem_to_reg),
    .i_exmem_rd         (r_exmem.rd),
    .i_memwb_valid      (r_memwb.valid),
    .i_memwb_reg_write  (r_memwb.reg_write),
    .i_memwb_rd         (r_memwb.rd),
    .i_src              (idex_rs),
    .o_sel              (forwarding_sel_a)
  );

  fwd_sel_logic #(.REG_AW(REG_AW)) u_fwd_sel_b (
    .i_exmem_valid      (r_exmem.valid),
    .i_exmem_reg_write  (r_exmem.reg_write),
    .i_exmem_mem_to_reg (r_exmem.mem_to_reg),
    .i_exmem_rd         (r_exmem.rd),
    .i_memwb_valid      (r_memwb.valid),
    .i_memwb_reg_write  (r_memwb.reg_write),
    .i_memwb_rd         (r_memwb.rd),
    .i_src              (idex_rt),
    .o_sel              (forwarding_sel_b)
  );

  assign ALU_Result_out   = r_exmem.data;
  assign MemToReg_Res_out = r_memwb.data;
  assign wb_rd            = r_memwb.rd;
  assign wb_reg_write     = r_memwb.valid & r_memwb.reg_write & (r_memwb.rd != '0);

  // Gated by reset_n so the stall request is quiet while the pipeline is being cleared.
  assign load_use_hazard = reset_n & ex_valid & ex_mem_to_reg & (ex_rd != '0) &
                           ((ex_rd == id_rs) | (ex_rd == id_rt));

`ifdef FWD_PERF_CNT_EN
  logic [31:0] r_fwd_cnt;
  logic [31:0] r_lu_stall_cnt;
  logic [1:0]  w_fwd_inc;

  assign w_fwd_inc = {1'b0, |forwarding_sel_a} + {1'b0, |forwarding_sel_b};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fwd_cnt      <= '0;
      r_lu_stall_cnt <= '0;
    end else if (!hold) begin
      r_fwd_cnt      <= r_fwd_cnt + {30'd0, w_fwd_inc};
      r_lu_stall_cnt <= r_lu_stall_cnt + {31'd0, load_use_hazard};
    end
  end

  assign fwd_cnt      = r_fwd_cnt;
  assign lu_stall_cnt = r_lu_stall_cnt;
`endif

endmodule

// File: doc/exmem_memwb_fwd_unit.md
Name: exmem_memwb_fwd_unit

Overview:
- Holds the EX/MEM and MEM/WB pipeline registers for the destination and result fields of the R-type/load datapath.
- Computes the 2-bit forwarding selects for both ALU operands, in the encoding the EX-stage operand muxes consume:
  - 00 = register-file data
  - 01 = EX/MEM ALU result
  - 10 = MEM/WB write-back value
- Exports the forwarded data buses, the write-back port, and a load-use hazard flag for the ID-stage stall logic.

Parameters:
- DATA_W, 32, datapath width.
- REG_AW, 5, register address width; register 0 is hard-wired zero.

Ports:
- clk  input  1  pipeline clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- hold  input  1  global freeze (memory wait); both registers keep their value.
- flush_exmem  input  1  squashes the instruction entering EX/MEM (branch resolve).
- ex_valid  input  1  the instruction in EX is real, not a bubble.
- ex_rd  input  REG_AW  destination register of the EX instruction.
- ex_reg_write  input  1  the EX instruction writes the register file.
- ex_mem_to_reg  input  1  the EX instruction is a load.
- ex_alu_result  input  DATA_W  ALU output in EX.
- mem_read_data  input  DATA_W  data memory output for the instruction in MEM.
- idex_rs  input  REG_AW  rs of the instruction currently in EX.
- idex_rt  input  REG_AW  rt of the instruction currently in EX.
- id_rs  input  REG_AW  rs of the instruction in ID.
- id_rt  input  REG_AW  rt of the instruction in ID.
- forwarding_sel_a  output  2  select for ALU operand A.
- forwarding_sel_b  output  2  select for ALU operand B.
- ALU_Result_out  output  DATA_W  registered EX/MEM ALU result.
- MemToReg_Res_out  output  DATA_W  registered MEM/WB write-back value.
- wb_rd  output  REG_AW  write-back destination.
- wb_reg_write  output  1  write-back enable.
- load_use_hazard  output  1  the ID instruction must stall one cycle.

Behaviour:
- Reset (async, reset_n=0): all EX/MEM and MEM/WB fields clear to 0, including the valid, reg_write, mem_to_reg, rd and data fields. All outputs are 0 while reset is asserted. Reset mid-instruction discards the in-flight instructions.
- EX/MEM update on each posedge with hold=0:
  - Captures valid = ex_valid & ~flush_exmem, plus rd, reg_write, mem_to_reg and alu_result.
  - A flushed entry keeps valid=0, so it forwards nothing and writes nothing.
- MEM/WB update on the same edge:
  - Captures valid, rd, reg_write from EX/MEM.
  - Write-back value = mem_read_data if the EX/MEM entry is a load, else the EX/MEM alu_result.
- hold=1: both registers are unchanged and take priority over flush_exmem.
- Latency:
  - ALU_Result_out is one cycle after EX.
  - MemToReg_Res_out, wb_rd and wb_reg_write are two cycles after EX.
  - wb_reg_write = MEM/WB valid & reg_write & (rd != 0).
- Forwarding select (combinational from registered state plus idex_rs/idex_rt), evaluated per operand with src = rs or rt:
  - 01 if EX/MEM is valid & reg_write & ~mem_to_reg & rd != 0 & rd == src.
  - Else 10 if MEM/WB is valid & reg_write & rd != 0 & rd == src.
  - Else 00.
  - EX/MEM has priority over MEM/WB (most recent producer).
  - Encoding 11 is never produced.
- load_use_hazard (combinational):
  - Asserted when ex_valid & ex_mem_to_reg & ex_rd != 0 & (ex_rd == id_rs | ex_rd == id_rt).
  - Independent of hold.
  - The stall controller inserts the bubble (ex_valid=0 next cycle). This block never forwards 01 for a load.
- Same register in both stages: the EX/MEM value wins.
- rd = 0 is never forwarded, even when ex_reg_write=1.

Optional Feature:
- FWD_PERF_CNT_EN defined:
  - Adds outputs fwd_cnt [31:0] and lu_stall_cnt [31:0], reset to 0.
  - fwd_cnt increments by the number of operands (0..2) with a nonzero select on each unheld cycle.
  - lu_stall_cnt increments once per cycle with load_use_hazard=1 and hold=0.
  - Both counters wrap at 2^32.
- Not defined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package:
  - FWD_SEL_RF=2'b00, FWD_SEL_EXMEM=2'b01, FWD_SEL_MEMWB=2'b10.
  - REG_ZERO=0.
  - Pipeline-entry struct typedef {valid, reg_write, mem_to_reg, rd, data}.
- One natural sub-module, fwd_sel_logic: the pure select computation, instantiated twice (operand A, operand B).

Test Plan:
- Back-to-back dependency: add $3←0x5 in EX, next instruction reads rs=$3 → forwarding_sel_a=01 and ALU_Result_out=0x5 in that cycle.
- Distance-2 dependency: producer of $4=0xA, one independent instruction, consumer rt=$4 → forwarding_sel_b=10 and MemToReg_Res_out=0xA.
- Double hazard: $7 written in both EX/MEM (0x11) and MEM/WB (0x22), consumer rs=$7 → forwarding_sel_a=01.
- Load-use: lw $8 in EX, ID reads $8 → load_use_hazard=1. After the bubble, consumer sees sel=10 with mem_read_data=0xDEAD forwarded.
- $zero and flush: ex_rd=0 with reg_write → sel stays 00. flush_exmem with ex_rd=$5 → no forward, and wb_reg_write=0 two cycles later.
- Hold and reset: hold=1 for 3 cycles keeps outputs stable. reset_n dropped mid-pipeline → all outputs 0 immediately, without waiting for a clock edge.
